// File: rtl/strhw_common_types.sv
// Shared types and constants for the streaming hash stage.
// Holds Gn status, FSM/phase enums, word types and the IVs.
package strhw_common_types;

    localparam int BLOCK_SIZE = 64;

    typedef logic [511:0] uint512;
    typedef logic [6:0]   uint7;

    // Status reported by the external Gn unit
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_G_TRG,
        S_G_ARM,
        S_G_WAIT,
        S_DRAIN
    } fsm_t;

    typedef enum logic [1:0] {
        PH_MSG,
        PH_PAD,
        PH_FIN_N,
        PH_FIN_SIG
    } phase_t;

    localparam uint512 IV512 = '0;
    localparam uint512 IV256 = {64{8'h01}};

    // Sizes above one block are treated as a full block
    function automatic uint7 clamp_size(input uint7 s);
        return (s > 7'(BLOCK_SIZE)) ? 7'(BLOCK_SIZE) : s;
    endfunction

endpackage

// File: rtl/strhw_pad.sv
// Combinational masking and padding of a message block.
// Ports: block_i (512b), size_i (valid bytes 0..64), padded_o.
module strhw_pad
    import strhw_common_types::*;
(
    input  logic [511:0] block_i,
    input  logic [6:0]   size_i,
    output logic [511:0] padded_o
);

    // Bytes below size pass, byte at size gets the 0x01 marker,
    // everything above is zero. A full block gets no marker.
    always_comb begin
        padded_o = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            if (i < int'(size_i)) begin
                padded_o[8*i +: 8] = block_i[8*i +: 8];
            end else if (i == int'(size_i)) begin
                padded_o[8*i +: 8] = 8'h01;
            end
        end
    end

endmodule

// File: rtl/strhw_stream_stage.sv
// Streaming hash control stage driving an external Gn unit.
// Ports: block handshake (blk_*), abort_i, digest_o/valid, busy_o,
// Gn operands/trigger (g_n_*_o) and Gn result/status (g_n_*_i).
module strhw_stream_stage
    import strhw_common_types::*;
#(
    parameter int DIGEST_BITS = 512
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         blk_valid_i,
    output logic         blk_ready_o,
    input  logic [511:0] block_i,
    input  logic [6:0]   block_size_i,
    input  logic         last_i,
    input  logic         abort_i,
    output logic [511:0] digest_o,
    output logic         digest_valid_o,
    output logic         busy_o,
    output logic [511:0] g_n_m_o,
    output logic [511:0] g_n_n_o,
    output logic [511:0] g_n_h_o,
    output logic         g_n_trg_o,
    input  logic [511:0] g_n_result_i,
    input  state_t       g_n_state_i
);

    if (DIGEST_BITS != 512 && DIGEST_BITS != 256) begin : g_bad_bits
        $error("DIGEST_BITS must be 512 or 256");
    end

    localparam uint512 IV = (DIGEST_BITS == 256) ? IV256 : IV512;

    fsm_t   st_q;
    phase_t ph_q;
    uint512 h_q, n_q, s_q;
    uint512 opm_q, opn_q, oph_q;
    uint512 dig_q;
    uint7   sz_q;
    logic   last_q, full_q;
    logic   abrt_q, rdy_q, trg_q, dv_q;

    uint7   sz_in;
    logic   full_in;
    uint512 pad_w, msg_m;
    logic   accept;
    uint512 n_add, n_upd, s_upd;
    phase_t nxt_ph;
    uint512 opm_nx, opn_nx, dig_nx;
    logic   gn_done;

    assign sz_in   = clamp_size(block_size_i);
    assign full_in = (sz_in == 7'(BLOCK_SIZE));

    strhw_pad u_pad (
        .block_i  (block_i),
        .size_i   (sz_in),
        .padded_o (pad_w)
    );

    // A short final block is padded up front; a full final block
    // goes out raw and the marker block follows in the PAD phase.
    assign msg_m = (last_i && !full_in) ? pad_w : block_i;

    assign accept = (st_q == S_IDLE) && rdy_q
                 && blk_valid_i && !abort_i;

    assign gn_done = (g_n_state_i == DONE);

    always_comb begin
        n_add = '0;
        if (ph_q == PH_MSG) begin
            n_add = (last_q && !full_q)
                  ? {502'd0, sz_q, 3'd0}
                  : 512'd512;
        end
        n_upd = n_q + n_add;
        s_upd = s_q + opm_q;

        nxt_ph = PH_FIN_SIG;
        unique case (ph_q)
            PH_MSG:   nxt_ph = full_q ? PH_PAD : PH_FIN_N;
            PH_PAD:   nxt_ph = PH_FIN_N;
            PH_FIN_N: nxt_ph = PH_FIN_SIG;
            default:  nxt_ph = PH_FIN_SIG;
        endcase

        opm_nx = (nxt_ph == PH_PAD) ? 512'd1 : '0;
        opn_nx = (nxt_ph == PH_FIN_SIG) ? s_upd : n_upd;

        if (DIGEST_BITS == 256) begin
            dig_nx = {256'd0, g_n_result_i[511:256]};
        end else begin
            dig_nx = g_n_result_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q   <= S_IDLE;
            ph_q   <= PH_MSG;
            h_q    <= IV;
            n_q    <= '0;
            s_q    <= '0;
            opm_q  <= '0;
            opn_q  <= '0;
            oph_q  <= '0;
            dig_q  <= '0;
            sz_q   <= '0;
            last_q <= 1'b0;
            full_q <= 1'b0;
            abrt_q <= 1'b0;
            rdy_q  <= 1'b0;
            trg_q  <= 1'b0;
            dv_q   <= 1'b0;
        end else begin
            trg_q <= 1'b0;
            dv_q  <= 1'b0;
            unique case (st_q)
                S_IDLE: begin
                    rdy_q <= 1'b1;
                    if (abort_i) begin
                        h_q <= IV;
                        n_q <= '0;
                        s_q <= '0;
                    end else if (accept) begin
                        rdy_q  <= 1'b0;
                        last_q <= last_i;
                        full_q <= full_in;
                        sz_q   <= sz_in;
                        ph_q   <= PH_MSG;
                        oph_q  <= h_q;
                        opn_q  <= n_q;
                        opm_q  <= msg_m;
                        trg_q  <= 1'b1;
                        st_q   <= S_G_TRG;
                    end
                end
                S_G_TRG: begin
                    if (abort_i) begin
                        abrt_q <= 1'b1;
                    end
                    st_q <= S_G_ARM;
                end
                // The extra ARM cycle lets Gn leave a stale DONE
                // before G_WAIT starts looking at its status.
                S_G_ARM: begin
                    abrt_q <= 1'b0;
                    if (abrt_q || abort_i) begin
                        st_q <= S_DRAIN;
                    end else begin
                        st_q <= S_G_WAIT;
                    end
                end
                S_G_WAIT: begin
                    if (abort_i) begin
                        st_q <= S_DRAIN;
                    end else if (gn_done) begin
                        if (ph_q == PH_FIN_SIG) begin
                            dig_q <= dig_nx;
                            dv_q  <= 1'b1;
                            h_q   <= IV;
                            n_q   <= '0;
                            s_q   <= '0;
                            rdy_q <= 1'b1;
                            st_q  <= S_IDLE;
                        end else begin
                            h_q <= g_n_result_i;
                            n_q <= n_upd;
                            s_q <= s_upd;
                            if (ph_q == PH_MSG && !last_q) begin
                                rdy_q <= 1'b1;
                                st_q  <= S_IDLE;
                            end else begin
                                ph_q  <= nxt_ph;
                                oph_q <= g_n_result_i;
                                opn_q <= opn_nx;
                                opm_q <= opm_nx;
                                trg_q <= 1'b1;
                                st_q  <= S_G_TRG;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (g_n_state_i != BUSY) begin
                        h_q   <= IV;
                        n_q   <= '0;
                        s_q   <= '0;
                        rdy_q <= 1'b1;
                        st_q  <= S_IDLE;
                    end
                end
                default: st_q <= S_IDLE;
            endcase
        end
    end

    // abort_i wins over a block offered in the same cycle
    assign blk_ready_o    = rdy_q && !abort_i;
    assign busy_o         = (st_q != S_IDLE);
    assign digest_o       = dig_q;
    assign digest_valid_o = dv_q;
    assign g_n_m_o        = opm_q;
    assign g_n_n_o        = opn_q;
    assign g_n_h_o        = oph_q;
    assign g_n_trg_o      = trg_q;

endmodule

// File: tb/tb_strhw_stream_stage.sv
// Scoreboard bench for strhw_stream_stage, 512 and 256 bit instances.
// A stand-in Gn unit with adjustable latency drives both instances.
module tb_strhw_stream_stage;
    import strhw_common_types::*;

    typedef struct {
        logic [511:0] d;
        int           t0;
        int           nt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         vld, lst, abt;
    logic [511:0] blk;
    logic [6:0]   bsz;
    logic         rdy [2];
    logic         dv  [2];
    logic         bsy [2];
    logic         trg [2];
    logic [511:0] dig [2];
    logic [511:0] gm  [2];
    logic [511:0] gn  [2];
    logic [511:0] gh  [2];
    logic [511:0] gres[2];
    state_t       gst [2];

    int           gcnt     [2];
    logic [511:0] gpend    [2];
    logic [511:0] glast_n  [2];
    int           trg_total[2];
    int           gn_lat;

    int nchk = 0;
    int nerr = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    logic [511:0] last_exp[2];

    strhw_stream_stage #(.DIGEST_BITS(512)) u_d512 (
        .clk_i(clk), .rst_i(rst),
        .blk_valid_i(vld), .blk_ready_o(rdy[0]),
        .block_i(blk), .block_size_i(bsz), .last_i(lst),
        .abort_i(abt),
        .digest_o(dig[0]), .digest_valid_o(dv[0]),
        .busy_o(bsy[0]),
        .g_n_m_o(gm[0]), .g_n_n_o(gn[0]), .g_n_h_o(gh[0]),
        .g_n_trg_o(trg[0]),
        .g_n_result_i(gres[0]), .g_n_state_i(gst[0])
    );

    strhw_stream_stage #(.DIGEST_BITS(256)) u_d256 (
        .clk_i(clk), .rst_i(rst),
        .blk_valid_i(vld), .blk_ready_o(rdy[1]),
        .block_i(blk), .block_size_i(bsz), .last_i(lst),
        .abort_i(abt),
        .digest_o(dig[1]), .digest_valid_o(dv[1]),
        .busy_o(bsy[1]),
        .g_n_m_o(gm[1]), .g_n_n_o(gn[1]), .g_n_h_o(gh[1]),
        .g_n_trg_o(trg[1]),
        .g_n_result_i(gres[1]), .g_n_state_i(gst[1])
    );

    // Stand-in compression: any mixing of all three operands works
    function automatic logic [511:0] gn_f(
        input logic [511:0] h, input logic [511:0] n,
        input logic [511:0] m);
        return ({h[498:0], h[511:499]} + (n * 512'd3))
             ^ {m[3:0], m[511:4]} ^ 512'h9E3779B97F4A7C15;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                gst[k]  <= CLEAR;
                gres[k] <= '0;
                gcnt[k] <= 0;
            end else if (trg[k]) begin
                gst[k]       <= BUSY;
                gcnt[k]      <= gn_lat;
                gpend[k]     <= gn_f(gh[k], gn[k], gm[k]);
                glast_n[k]   <= gn[k];
                trg_total[k] <= trg_total[k] + 1;
            end else if (gst[k] == BUSY) begin
                if (gcnt[k] <= 1) begin
                    gst[k]  <= DONE;
                    gres[k] <= gpend[k];
                end else begin
                    gcnt[k] <= gcnt[k] - 1;
                end
            end
        end
    end

    // Reference: chaining rules applied to a list of blocks
    function automatic void ref_hash(
        input logic [511:0] blks[$], input int lsz,
        input bit b256, output logic [511:0] d, output int nt);
        logic [511:0] h, n, s, p, fin;
        int sz;
        h = b256 ? {64{8'h01}} : '0;
        n = '0;
        s = '0;
        nt = 0;
        for (int i = 0; i < blks.size() - 1; i++) begin
            h = gn_f(h, n, blks[i]);
            n = n + 512;
            s = s + blks[i];
            nt++;
        end
        fin = blks[blks.size() - 1];
        sz = (lsz > 64) ? 64 : lsz;
        if (sz == 64) begin
            h = gn_f(h, n, fin);
            n = n + 512;
            s = s + fin;
            nt++;
            fin = '0;
            sz = 0;
        end
        p = '0;
        for (int b = 0; b < sz; b++) p[8*b +: 8] = fin[8*b +: 8];
        p[8*sz] = 1'b1;
        h = gn_f(h, n, p);
        n = n + 512'(8 * sz);
        s = s + p;
        h = gn_f(h, n, '0);
        h = gn_f(h, s, '0);
        nt += 3;
        d = b256 ? {256'd0, h[511:256]} : h;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk512(input string nm, input logic [511:0] got,
                          input logic [511:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic got,
                        input logic exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%b exp=%b", nm, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got,
                           input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic timeout(input string nm);
        nchk++;
        nerr++;
        $display("FAIL %s timeout got=stuck exp=progress", nm);
    endtask

    task automatic wait_idle();
        int to = 0;
        @(negedge clk);
        while (bsy[0] && to < 3000) begin
            @(negedge clk);
            to++;
        end
        if (to >= 3000) timeout("wait_idle");
    endtask

    task automatic send_blk(input logic [511:0] d, input int sz,
                            input bit l);
        int to = 0;
        blk = d;
        bsz = 7'(sz);
        lst = l;
        vld = 1'b1;
        while (!rdy[0] && to < 3000) begin
            @(negedge clk);
            to++;
        end
        if (to >= 3000) begin
            timeout("send_blk");
        end else begin
            @(posedge clk);
            #1;
        end
        vld = 1'b0;
    endtask

    task automatic run_msg(input int nfull, input int lsz,
                           input bit chk_n);
        logic [511:0] blks[$];
        logic [511:0] d;
        int nt;
        exp_t e;
        wait_idle();
        for (int i = 0; i <= nfull; i++) blks.push_back(rnd512());
        for (int k = 0; k < 2; k++) begin
            ref_hash(blks, lsz, k == 1, d, nt);
            e.d = d;
            e.t0 = trg_total[k];
            e.nt = nt;
            last_exp[k] = d;
            if (k == 0) sb0.push_back(e);
            else sb1.push_back(e);
        end
        for (int i = 0; i < nfull; i++)
            send_blk(blks[i], $urandom_range(0, 127), 1'b0);
        send_blk(blks[nfull], lsz, 1'b1);
        if (chk_n) begin
            repeat (3) @(negedge clk);
            chk512("n_after_blk1_512", glast_n[0], 512'd512);
            chk512("n_after_blk1_256", glast_n[1], 512'd512);
        end
        wait_idle();
    endtask

    task automatic hold_chk();
        repeat (6) @(negedge clk);
        chk512("hold_512", dig[0], last_exp[0]);
        chk512("hold_256", dig[1], last_exp[1]);
    endtask

    task automatic reset_chk(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk1({tag, "_ready"}, rdy[k], 1'b0);
            chk1({tag, "_busy"}, bsy[k], 1'b0);
            chk1({tag, "_dvalid"}, dv[k], 1'b0);
            chk1({tag, "_trg"}, trg[k], 1'b0);
            chk512({tag, "_digest"}, dig[k], '0);
            chk512({tag, "_gm"}, gm[k], '0);
            chk512({tag, "_gn"}, gn[k], '0);
            chk512({tag, "_gh"}, gh[k], '0);
        end
    endtask

    initial begin
        vld = 1'b0;
        lst = 1'b0;
        abt = 1'b0;
        blk = '0;
        bsz = '0;
        gn_lat = 4;
        rst = 1'b0;
        last_exp[0] = '0;
        last_exp[1] = '0;
        for (int k = 0; k < 2; k++) trg_total[k] = 0;
        #1 rst = 1'b1;
        fork
            begin : mon
                exp_t e;
                forever begin
                    @(negedge clk);
                    for (int k = 0; k < 2; k++) begin
                        if (!rst && dv[k]) begin
                            if ((k == 0 ? sb0.size() : sb1.size()) == 0) begin
                                nchk++;
                                nerr++;
                                $display("FAIL unexpected_digest inst=%0d got=pulse exp=none", k);
                            end else begin
                                e = (k == 0) ? sb0.pop_front()
                                             : sb1.pop_front();
                                chk512(k == 0 ? "digest_512" : "digest_256",
                                       dig[k], e.d);
                                chk_int(k == 0 ? "trig_512" : "trig_256",
                                        trg_total[k] - e.t0, e.nt);
                            end
                        end
                    end
                end
            end
            begin : drv
                int to;
                logic [511:0] b;
                repeat (3) @(negedge clk);
                reset_chk("rst");
                rst = 1'b0;
                @(posedge clk);
                #1;
                chk1("ready_after_rst_512", rdy[0], 1'b1);
                chk1("ready_after_rst_256", rdy[1], 1'b1);

                run_msg(0, 63, 1'b0);
                hold_chk();
                run_msg(1, 8, 1'b1);
                run_msg(0, 64, 1'b0);
                run_msg(0, 0, 1'b0);
                hold_chk();
                run_msg(1, 100, 1'b0);

                gn_lat = 10;
                wait_idle();
                send_blk(rnd512(), 17, 1'b0);
                send_blk(rnd512(), 40, 1'b1);
                repeat (4) @(negedge clk);
                abt = 1'b1;
                @(posedge clk);
                #1 abt = 1'b0;
                @(negedge clk);
                chk1("drain_ready", rdy[0], 1'b0);
                chk1("drain_busy", bsy[0], 1'b1);
                wait_idle();
                chk1("post_drain_ready", rdy[0], 1'b1);
                run_msg(0, 63, 1'b0);

                gn_lat = 3;
                wait_idle();
                send_blk(rnd512(), 0, 1'b0);
                send_blk(rnd512(), 5, 1'b1);
                abt = 1'b1;
                @(posedge clk);
                #1 abt = 1'b0;
                wait_idle();
                run_msg(0, 30, 1'b0);

                send_blk(rnd512(), 64, 1'b0);
                wait_idle();
                blk = rnd512();
                bsz = 7'd9;
                lst = 1'b1;
                vld = 1'b1;
                abt = 1'b1;
                @(posedge clk);
                #1;
                vld = 1'b0;
                abt = 1'b0;
                @(negedge clk);
                chk1("abort_priority", bsy[0], 1'b0);
                run_msg(0, 12, 1'b0);

                send_blk(rnd512(), 64, 1'b0);
                send_blk(rnd512(), 20, 1'b1);
                repeat (3) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                reset_chk("midrst");
                last_exp[0] = '0;
                last_exp[1] = '0;
                rst = 1'b0;
                @(posedge clk);
                #1;
                chk1("ready_after_midrst", rdy[0], 1'b1);
                run_msg(0, 63, 1'b0);

                for (int i = 0; i < 20; i++) begin
                    gn_lat = $urandom_range(1, 10);
                    run_msg($urandom_range(0, 2),
                            $urandom_range(0, 70), 1'b0);
                end
                hold_chk();

                to = 0;
                while ((sb0.size() != 0 || sb1.size() != 0)
                       && to < 200) begin
                    @(negedge clk);
                    to++;
                end
                if (to >= 200) timeout("scoreboard_drain");
                b = '0;
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors",
                 nchk, nerr);
        $finish;
    end

endmodule

// File: doc/strhw_stream_stage.md
STRHW_STREAM_STAGE -- requirements
Module: strhw_stream_stage

Interface
REQ-001 Parameter: DIGEST_BITS, default 512, digest length; legal values 512 and 256, anything else is an elaboration error.
REQ-002 Port: clk_i  in  1  sole clock, rising edge.
REQ-003 Port: rst_i  in  1  reset, asynchronous, active-high.
REQ-004 Port: blk_valid_i  in  1  block offered; blk_ready_o  out  1  block accepted on valid&ready.
REQ-005 Port: block_i  in  512  message block, byte 0 at bits [7:0]; block_size_i  in  7  valid bytes, 0..64; last_i  in  1  final block of the message.
REQ-006 Port: abort_i  in  1  discard the message in progress.
REQ-007 Port: digest_o  out  512  result, zero-extended in bits [511:256] when DIGEST_BITS=256; digest_valid_o  out  1  one-cycle pulse.
REQ-008 Port: busy_o  out  1  high in every state except IDLE.
REQ-009 Port: g_n_m_o, g_n_n_o, g_n_h_o  out  512 each  operands to the external Gn unit; g_n_trg_o  out  1  Gn start pulse.
REQ-010 Port: g_n_result_i  in  512  Gn result; g_n_state_i  in  state_t  Gn status (CLEAR/BUSY/DONE).

Function
REQ-011 The block SHALL hold h, n and sigma internally; IV is all-zero for 512 and 0x01 in every byte for 256.
REQ-012 States: IDLE, G_TRG, G_ARM, G_WAIT, DRAIN; a phase register selects MSG, PAD, FIN_N or FIN_SIG.
REQ-013 IDLE: blk_ready_o=1; on accept, latch the block and go to G_TRG with phase MSG.
REQ-014 G_TRG SHALL drive the operands and g_n_trg_o=1 for exactly one cycle; G_ARM follows with trg=0; G_WAIT holds until g_n_state_i==DONE.
REQ-015 MSG with last_i=0: block_size_i is ignored; operands (h, n, block); on DONE, h=result, n+=512, sigma+=block, return to IDLE.
REQ-016 MSG with last_i=1 and size<64: padded = block with bytes >= size zeroed, OR 1<<(8*size); operands (h, n, padded); on DONE, h=result, n+=8*size, sigma+=padded, go to phase FIN_N.
REQ-017 MSG with last_i=1 and size>=64 (sizes above 64 are treated as 64): process the block as in REQ-015, then run phase PAD with padded=1, size 0, before FIN_N.
REQ-018 FIN_N SHALL use operands (h, n, 0); FIN_SIG SHALL use operands (h, sigma, 0); each sets h=result.
REQ-019 After FIN_SIG DONE: digest_o = result (512) or {256'h0, result[511:256]} (256); pulse digest_valid_o; reload the IV; go to IDLE.
REQ-020 All additions SHALL be modulo 2^512.
REQ-021 abort_i in IDLE SHALL reload the IV in the next cycle.
REQ-022 abort_i in G_WAIT SHALL go to DRAIN; DRAIN waits for g_n_state_i != BUSY, discards the result, reloads the IV, goes to IDLE; no digest_valid_o is produced.
REQ-023 abort_i in G_TRG/G_ARM SHALL complete the trigger, then enter DRAIN.
REQ-024 abort_i SHALL have priority over a simultaneous blk_valid_i; blk_ready_o=0 during DRAIN.
REQ-025 digest_o SHALL hold its value until the next digest.

Reset
REQ-026 While rst_i=1: state IDLE, h/n/sigma=IV, all 512-bit outputs 0, g_n_trg_o=0, digest_valid_o=0, busy_o=0, blk_ready_o=0.
REQ-027 blk_ready_o SHALL go to 1 on the first clock edge after release; reset mid-message drops the message without a digest.

Structure
REQ-028 The strhw_common_types package SHALL hold state_t, uint512, uint7, BLOCK_SIZE=64, IV512 and IV256.
REQ-029 One sub-module, strhw_pad, SHALL be combinational masking and padding of (block, size) to the padded block.

Verification
REQ-030 512-bit mode, 63-byte standard example M1 (one block, last=1, size=63) -> digest_o equals the standard's M1 512-bit hash.
REQ-031 256-bit mode, same M1 -> digest_o[255:0] equals the standard's 256-bit M1 hash and [511:256]=0.
REQ-032 Standard example M2 (72 bytes: a 64-byte block with last=0, then an 8-byte block with last=1) -> matches the standard's hash; n after block 1 is 512.
REQ-033 64-byte block with last=1 -> exactly four Gn triggers (MSG, PAD, FIN_N, FIN_SIG); result equals the golden model.
REQ-034 Gn model latency 10 cycles, abort_i during G_WAIT of block 1 -> no digest_valid_o; a following M1 hashes correctly.
REQ-035 Empty message (size 0, last=1) -> three Gn triggers; digest_o equals the golden empty-message hash.
